mem_responder: RTL and testbench

Multi-cycle data-memory responder: the target side of the pipeline's data-memory port. It accepts one read or write request per cycle under a valid/ready handshake, returns read data in order after a fixed parameterised latency, and optionally returns aligned 4-word bursts for cache-line fills. It replaces the single-cycle data memory behind the MEM stage, and the pipeline stalls on `ready`/`data_valid`.

---
 rtl/mem_responder.sv | 98 +++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: pipelined data-memory target with fixed read latency and registered outputs.
// Define MEM_RESPONDER_BURST_EN for aligned 4-word burst reads (cache-line fills).
module mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data_in,
  output logic                  ready,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  output logic [1:0]            resp_word
);
  localparam int IW = ADDR_WIDTH - 1;
  logic [15:0] mem [2**IW];
  logic [IW-1:0] idx;
  logic acc_rd, acc_wr, ready_q, ready_d, unused;
  logic [LATENCY-1:0] pv_q, pv_d;
  logic [15:0] pd_q [LATENCY];
  logic [15:0] pd_d [LATENCY];
  assign idx = addr[ADDR_WIDTH-1:1];
  assign unused = addr[0];
  assign acc_wr = enable & ready_q & wr;
  assign acc_rd = enable & ready_q & ~wr;
  assign ready = ready_q;
  assign data_valid = pv_q[LATENCY-1];
  assign data_out = pd_q[LATENCY-1];
  // storage has no reset so its contents survive rst
  always_ff @(posedge clk)
    if (acc_wr) mem[idx] <= data_in;
`ifdef MEM_RESPONDER_BURST_EN
  logic [1:0] cnt_q, cnt_d, rw_q, rw_d;
  logic busy_q, busy_d;
  logic [IW-3:0] base_q, base_d;
  assign resp_word = rw_q;
  // ready is low for the whole burst, so no write can land between accept and word 3;
  // burst words are therefore read from storage as they are issued
  always_comb begin
    pv_d[0] = acc_rd;
    pd_d[0] = '0;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    cnt_d = 2'd0;
    rw_d = 2'd0;
    base_d = acc_rd ? idx[IW-1:2] : base_q;
    busy_d = acc_rd | (busy_q & ~(pv_q[LATENCY-1] & (rw_q == 2'd3)));
    if (cnt_q != 2'd0) begin
      pv_d[LATENCY-1] = 1'b1;
      rw_d = cnt_q;
      cnt_d = cnt_q + 2'd1;
    end else if (pv_d[LATENCY-1]) begin
      cnt_d = 2'd1;
    end
    pd_d[LATENCY-1] = pv_d[LATENCY-1] ? mem[{base_d, rw_d}] : '0;
    ready_d = ~busy_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= 2'd0;
      rw_q <= 2'd0;
      busy_q <= 1'b0;
      base_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rw_q <= rw_d;
      busy_q <= busy_d;
      base_q <= base_d;
    end
`else
  assign resp_word = 2'b00;
  // read data is captured at the accept edge so later writes cannot alter it
  always_comb begin
    pv_d[0] = acc_rd;
    pd_d[0] = acc_rd ? mem[idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    ready_d = 1'b1;
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv_q <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q <= pv_d;
      ready_q <= ready_d;
      for (int i = 0; i < LATENCY; i++) pd_q[i] <= pd_d[i];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a queue-based response model.
module tb_mem_responder;
  localparam int AW = 16;
  localparam int L = 4;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [15:0] data_in = '0;
  logic ready, data_valid;
  logic [15:0] data_out;
  logic [1:0] resp_word;
  int n_chk = 0, n_fail = 0, edge_n = 0;
  typedef struct {int due; logic [15:0] d;} resp_t;
  resp_t q[$];
  logic [15:0] mem_m [int];
  logic ready_m = 1'b0, exp_v = 1'b0;
  logic [15:0] exp_d = '0;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .ready(ready), .data_out(data_out), .data_valid(data_valid), .resp_word(resp_word)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drive one cycle; model: a read accepted at edge E is due in the cycle after edge E+L-1
  task automatic step(input logic en, input logic w, input logic [AW-1:0] a, input logic [15:0] d);
    enable = en; wr = w; addr = a; data_in = d;
    @(posedge clk);
    edge_n++;
    if (rst) q.delete();
    else begin
      if (en && ready_m) begin
        if (w) mem_m[int'(a[AW-1:1])] = d;
        else q.push_back('{edge_n + L - 1, mem_m[int'(a[AW-1:1])]});
      end
      ready_m = 1'b1;
    end
    exp_v = 1'b0; exp_d = '0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      exp_v = 1'b1; exp_d = q[0].d; void'(q.pop_front());
    end
    #1;
    enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({ready, data_valid, data_out, resp_word} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: ready=%b valid=%b data=%h word=%0d, required all 0", k, ready, data_valid, data_out, resp_word);
      end
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_early: ready=%b, required 0", ready); end
    step(1'b0, 1'b0, '0, '0);
    n_chk++;
    if (ready !== 1'b1 || data_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", ready, data_valid);
    end
  endtask

`ifdef MEM_RESPONDER_BURST_EN
  task automatic test_burst();
    logic [15:0] d;
    for (int w = 4; w < 8; w++) begin
      step(1'b1, 1'b1, 16'(w * 2), 16'(16'h1111 * w));
      n_chk++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL burst_write_ready: ready=%b, required 1", ready); end
    end
    enable = 1'b1; wr = 1'b0; addr = 16'h000A;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int j = 0; j < L + 5; j++) begin
      d = (j >= L - 1 && j <= L + 2) ? 16'(16'h4444 + 16'h1111 * (j - L + 1)) : 16'h0;
      n_chk++;
      if (data_valid !== (j >= L - 1 && j <= L + 2) || data_out !== d ||
          resp_word !== ((j >= L - 1 && j <= L + 2) ? 2'(j - L + 1) : 2'd0) || ready !== (j > L + 2)) begin
        n_fail++;
        $display("FAIL burst cyc %0d: valid=%b data=%h word=%0d ready=%b, required data=%h ready=%b", j, data_valid, data_out, resp_word, ready, d, j > L + 2);
      end
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_write_read();
    int e0, nv;
    nv = 0;
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0011, 16'h0000);
    e0 = edge_n;
    for (int k = 0; k < L + 3; k++) begin
      n_chk++;
      if (data_valid !== exp_v || data_out !== exp_d || data_valid !== (edge_n == e0 + L - 1) ||
          (data_valid && data_out !== 16'hBEEF)) begin
        n_fail++;
        $display("FAIL write_read edge+%0d: valid=%b data=%h, required valid=%b data=%h", edge_n - e0, data_valid, data_out, edge_n == e0 + L - 1, exp_d);
      end
      nv += int'(data_valid);
      step(1'b0, 1'b0, '0, '0);
    end
    n_chk++;
    if (nv != 1) begin n_fail++; $display("FAIL write_read_count: %0d valid cycles, required 1", nv); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [3];
    int nv, first;
    seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333;
    nv = 0; first = -1;
    for (int w = 0; w < 3; w++) step(1'b1, 1'b1, 16'(w * 2), seq[w]);
    for (int k = 0; k < L + 5; k++) begin
      step(k < 3, 1'b0, 16'(k * 2), '0);
      if (data_valid && first < 0) first = k;
      n_chk++;
      if (data_valid !== exp_v || data_out !== exp_d ||
          (first >= 0 && k - first < 3 && (data_valid !== 1'b1 || data_out !== seq[k - first]))) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: valid=%b data=%h, required valid=%b data=%h", k, data_valid, data_out, exp_v, exp_d);
      end
      nv += int'(data_valid);
    end
    n_chk++;
    if (nv != 3 || first != L - 1) begin
      n_fail++; $display("FAIL back_to_back_count: %0d valid from cyc %0d, required 3 from cyc %0d", nv, first, L - 1);
    end
  endtask

  task automatic test_read_before_write();
    logic [15:0] want;
    int nv;
    step(1'b1, 1'b1, 16'h000A, 16'h0005);
    for (int pass = 0; pass < 2; pass++) begin
      want = pass == 0 ? 16'h0005 : 16'hAAAA;
      nv = 0;
      step(1'b1, 1'b0, 16'h000A, '0);
      if (pass == 0) step(1'b1, 1'b1, 16'h000A, 16'hAAAA);
      for (int k = 0; k < L + 2; k++) begin
        n_chk++;
        if (data_valid !== exp_v || data_out !== exp_d || (data_valid && data_out !== want)) begin
          n_fail++;
          $display("FAIL read_before_write pass %0d cyc %0d: valid=%b data=%h, required data=%h", pass, k, data_valid, data_out, want);
        end
        nv += int'(data_valid);
        step(1'b0, 1'b0, '0, '0);
      end
      n_chk++;
      if (nv != 1) begin n_fail++; $display("FAIL read_before_write_count pass %0d: %0d valid, required 1", pass, nv); end
    end
  endtask

  task automatic test_reset_midflight();
    int nv;
    nv = 0;
    step(1'b1, 1'b1, 16'h0012, 16'h1234);
    step(1'b1, 1'b0, 16'h0012, '0);
    @(posedge clk); #1;
    rst = 1'b1; q.delete(); ready_m = 1'b0;
    #1;
    n_chk++;
    if ({ready, data_valid, data_out, resp_word} !== 20'h0) begin
      n_fail++; $display("FAIL reset_midflight_async: ready=%b valid=%b data=%h, required all 0", ready, data_valid, data_out);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int k = 0; k < L + 2; k++) begin
      step(1'b0, 1'b0, '0, '0);
      nv += int'(data_valid);
    end
    n_chk++;
    if (nv != 0) begin n_fail++; $display("FAIL reset_midflight_discard: %0d valid cycles, required 0", nv); end
    step(1'b1, 1'b0, 16'h0012, '0);
    for (int k = 0; k < L + 2; k++) begin
      n_chk++;
      if (data_valid !== exp_v || data_out !== exp_d || (data_valid && data_out !== 16'h1234)) begin
        n_fail++; $display("FAIL reset_midflight_fresh cyc %0d: valid=%b data=%h, required valid=%b data=%h", k, data_valid, data_out, exp_v, exp_d);
      end
      nv += int'(data_valid);
      step(1'b0, 1'b0, '0, '0);
    end
    n_chk++;
    if (nv != 1) begin n_fail++; $display("FAIL reset_midflight_fresh_count: %0d valid, required 1", nv); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int w = 32; w < 64; w++) step(1'b1, 1'b1, 16'(w * 2), 16'($urandom));
    for (int k = 0; k < 400 + L; k++) begin
      a = 16'($urandom_range(32, 63) * 2 + $urandom_range(0, 1));
      step(k < 400 && ($urandom % 4) != 0, ($urandom % 3) == 0, a, 16'($urandom));
      n_chk++;
      if (data_valid !== exp_v || data_out !== exp_d || resp_word !== 2'd0 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL random cyc %0d: valid=%b data=%h word=%0d ready=%b, required valid=%b data=%h word=0 ready=1", k, data_valid, data_out, resp_word, ready, exp_v, exp_d);
      end
    end
    n_chk++;
    if (q.size() != 0) begin n_fail++; $display("FAIL random_drain: %0d responses outstanding, required 0", q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MEM_RESPONDER_BURST_EN
    test_burst();
`else
    test_write_read();
    test_back_to_back();
    test_read_before_write();
    test_reset_midflight();
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
